// File: rtl/mmio_csr_bridge.sv
// Purpose: host MMIO responder that decodes CSR writes into strobes and answers reads from header/UUID/app CSRs.
// Latency: write strobe one cycle after the request; read response valid two cycles after the request when uncongested.
// Backpressure: mmio_rsp_ready stalls the response FIFO head; reads that would overflow S1 plus the FIFO are dropped and counted.
module mmio_csr_bridge #(
    parameter int          NUM_APP_CSRS   = 8,
    parameter logic [15:0] APP_CSR_BASE   = 16'h0020,
    parameter int          RSP_FIFO_DEPTH = 4,
    parameter logic [63:0] DFH_VALUE      = 64'h1000_0000_0000_1000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mmio_req_valid,
    input  logic                       mmio_req_write,
    input  logic [15:0]                mmio_req_addr,
    input  logic                       mmio_req_len,
    input  logic [8:0]                 mmio_req_tid,
    input  logic [63:0]                mmio_req_data,
    output logic                       mmio_rsp_valid,
    input  logic                       mmio_rsp_ready,
    output logic [8:0]                 mmio_rsp_tid,
    output logic [63:0]                mmio_rsp_data,
    output logic [NUM_APP_CSRS-1:0]    csr_wr_en,
    output logic [63:0]                csr_wr_data,
    input  logic [64*NUM_APP_CSRS-1:0] csr_rd_data,
    input  logic [127:0]               afu_id,
    output logic [7:0]                 drop_count
);

    localparam int IW = (NUM_APP_CSRS > 1) ? $clog2(NUM_APP_CSRS) : 1;
    localparam int PW = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        SEL_ZERO,
        SEL_DFH,
        SEL_ID_LO,
        SEL_ID_HI,
        SEL_APP
    } sel_t;

    typedef struct packed {
        logic [8:0]  tid;
        logic [63:0] data;
    } rsp_t;

    // Request decode (shared by reads and writes; writes require addr[0]=0 so the QWORD address equals the raw one)
    logic [15:0]             w_qaddr;
    logic [15:0]             w_app_off;
    logic                    w_app_hit;
    logic [IW-1:0]           w_app_idx;
    sel_t                    w_rd_sel;
    logic                    w_wr_strobe;
    logic                    w_wr_drop;
    logic                    w_rd_req;
    logic                    w_rd_accept;
    logic                    w_rd_drop;
    logic [CW-1:0]           w_occ;
    logic [NUM_APP_CSRS-1:0] w_wr_onehot;

    // Read pipeline and FIFO state
    logic                    r_s1_vld;
    logic [8:0]              r_s1_tid;
    sel_t                    r_s1_sel;
    logic [IW-1:0]           r_s1_idx;
    logic [63:0]             w_s2_data;
    rsp_t                    r_mem [RSP_FIFO_DEPTH];
    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_count;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_rsp_vld;
    rsp_t                    w_head;

    logic [NUM_APP_CSRS-1:0] r_wr_en;
    logic [63:0]             r_wr_data;
    logic [7:0]              r_drop;

    assign w_qaddr   = {mmio_req_addr[15:1], 1'b0};
    assign w_app_off = w_qaddr - APP_CSR_BASE;
    assign w_app_hit = (w_qaddr >= APP_CSR_BASE) && (w_app_off[0] == 1'b0) &&
                       (32'(w_app_off[15:1]) < 32'(NUM_APP_CSRS));
    assign w_app_idx = w_app_off[IW:1];

    assign w_wr_strobe = mmio_req_valid && mmio_req_write && mmio_req_len &&
                         !mmio_req_addr[0] && w_app_hit;
    assign w_wr_drop   = mmio_req_valid && mmio_req_write &&
                         (!mmio_req_len || mmio_req_addr[0]);

    // S1 plus FIFO occupancy bounds admission so an accepted read always has a FIFO slot
    assign w_occ       = r_count + CW'(r_s1_vld);
    assign w_rd_req    = mmio_req_valid && !mmio_req_write;
    assign w_rd_accept = w_rd_req && (w_occ < CW'(RSP_FIFO_DEPTH));
    assign w_rd_drop   = w_rd_req && !w_rd_accept;

    // Classify the read address into a data source
    always_comb begin
        w_rd_sel = SEL_ZERO;
        if (w_qaddr == 16'h0000)      w_rd_sel = SEL_DFH;
        else if (w_qaddr == 16'h0002) w_rd_sel = SEL_ID_LO;
        else if (w_qaddr == 16'h0004) w_rd_sel = SEL_ID_HI;
        else if (w_app_hit)           w_rd_sel = SEL_APP;
    end

    // One-hot write strobe for the addressed application CSR
    always_comb begin
        w_wr_onehot = '0;
        for (int i = 0; i < NUM_APP_CSRS; i++) begin
            w_wr_onehot[i] = w_wr_strobe && (w_app_idx == IW'(i));
        end
    end

    // Register the write strobe and its data; data holds between strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_en   <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_wr_onehot;
            if (w_wr_strobe) r_wr_data <= mmio_req_data;
        end
    end

    // S1: capture tid and decoded source of an admitted read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_vld <= 1'b0;
            r_s1_tid <= '0;
            r_s1_sel <= SEL_ZERO;
            r_s1_idx <= '0;
        end else begin
            r_s1_vld <= w_rd_accept;
            if (w_rd_accept) begin
                r_s1_tid <= mmio_req_tid;
                r_s1_sel <= w_rd_sel;
                r_s1_idx <= w_app_idx;
            end
        end
    end

    // S2: pick read data while the read sits in S1
    always_comb begin
        w_s2_data = '0;
        case (r_s1_sel)
            SEL_DFH:   w_s2_data = DFH_VALUE;
            SEL_ID_LO: w_s2_data = afu_id[63:0];
            SEL_ID_HI: w_s2_data = afu_id[127:64];
            SEL_APP: begin
                for (int i = 0; i < NUM_APP_CSRS; i++) begin
                    if (r_s1_idx == IW'(i)) w_s2_data = csr_rd_data[64*i +: 64];
                end
            end
            default:   w_s2_data = '0;
        endcase
    end

    assign w_push    = r_s1_vld;
    assign w_rsp_vld = (r_count != '0);
    assign w_pop     = w_rsp_vld && mmio_rsp_ready;
    assign w_head    = r_mem[r_rd_ptr];

    // FIFO storage needs no reset: the head is only visible while count is non-zero
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= '{tid: r_s1_tid, data: w_s2_data};
    end

    // FIFO pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

    // Saturating count of dropped writes and refused reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop <= '0;
        end else if ((w_wr_drop || w_rd_drop) && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    assign mmio_rsp_valid = w_rsp_vld;
    assign mmio_rsp_tid   = w_rsp_vld ? w_head.tid  : '0;
    assign mmio_rsp_data  = w_rsp_vld ? w_head.data : '0;
    assign csr_wr_en      = r_wr_en;
    assign csr_wr_data    = r_wr_data;
    assign drop_count     = r_drop;

endmodule

// File: tb/tb_mmio_csr_bridge.sv
// Purpose: self-checking bench for mmio_csr_bridge (directed steps then random traffic against a queue model).
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
// Backpressure: mmio_rsp_ready is held low or randomised to exercise FIFO stalls and read admission.
module tb_mmio_csr_bridge;

    localparam int          N     = 8;
    localparam int          DEPTH = 4;
    localparam int          BASE  = 'h20;
    localparam logic [63:0] DFH   = 64'h1000_0000_0000_1000;

    logic         clk = 1'b0;
    logic         reset;
    logic         mmio_req_valid;
    logic         mmio_req_write;
    logic [15:0]  mmio_req_addr;
    logic         mmio_req_len;
    logic [8:0]   mmio_req_tid;
    logic [63:0]  mmio_req_data;
    logic         mmio_rsp_valid;
    logic         mmio_rsp_ready;
    logic [8:0]   mmio_rsp_tid;
    logic [63:0]  mmio_rsp_data;
    logic [N-1:0] csr_wr_en;
    logic [63:0]  csr_wr_data;
    logic [64*N-1:0] csr_rd_data;
    logic [127:0] afu_id;
    logic [7:0]   drop_count;

    always #5 clk = ~clk;

    mmio_csr_bridge dut (
        .clk            (clk),
        .reset          (reset),
        .mmio_req_valid (mmio_req_valid),
        .mmio_req_write (mmio_req_write),
        .mmio_req_addr  (mmio_req_addr),
        .mmio_req_len   (mmio_req_len),
        .mmio_req_tid   (mmio_req_tid),
        .mmio_req_data  (mmio_req_data),
        .mmio_rsp_valid (mmio_rsp_valid),
        .mmio_rsp_ready (mmio_rsp_ready),
        .mmio_rsp_tid   (mmio_rsp_tid),
        .mmio_rsp_data  (mmio_rsp_data),
        .csr_wr_en      (csr_wr_en),
        .csr_wr_data    (csr_wr_data),
        .csr_rd_data    (csr_rd_data),
        .afu_id         (afu_id),
        .drop_count     (drop_count)
    );

    typedef struct {
        logic [8:0]  tid;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          now   = 0;
    exp_t        q[$];
    exp_t        e;
    int          m_drop;
    logic [N-1:0] m_wr_en;
    logic [63:0] m_wr_data;
    logic        exp_vld;
    logic        do_pop;
    logic [N-1:0] en_seen;
    logic [15:0] a;
    logic        l;
    logic [8:0]  t;
    int          op;
    int          widx;
    logic [15:0] addr_tbl [12] = '{16'h0, 16'h1, 16'h2, 16'h4, 16'h5, 16'h6,
                                    16'h8, 16'h20, 16'h27, 16'h2E, 16'h30, 16'h100};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        now++;
    endtask

    task automatic idle();
        mmio_req_valid = 1'b0;
        mmio_req_write = 1'b0;
        mmio_req_len   = 1'b0;
        mmio_req_addr  = '0;
        mmio_req_tid   = '0;
        mmio_req_data  = '0;
    endtask

    task automatic req(input logic wr, input logic [15:0] ad, input logic ln,
                       input logic [8:0] td, input logic [63:0] dt);
        mmio_req_valid = 1'b1;
        mmio_req_write = wr;
        mmio_req_addr  = ad;
        mmio_req_len   = ln;
        mmio_req_tid   = td;
        mmio_req_data  = dt;
    endtask

    // Address map expressed directly as arithmetic on the QWORD address
    function automatic logic [63:0] ref_rd(input logic [15:0] ad);
        int qa;
        qa = int'(ad) & ~1;
        if (qa == 0) return DFH;
        if (qa == 2) return afu_id[63:0];
        if (qa == 4) return afu_id[127:64];
        if (qa >= BASE && qa < BASE + 2*N) return csr_rd_data[64*((qa-BASE)/2) +: 64];
        return 64'h0;
    endfunction

    // Index of the CSR strobed by an 8-byte aligned write, or -1
    function automatic int ref_wr_idx(input logic [15:0] ad, input logic ln);
        int v;
        v = int'(ad);
        if (!ln || ad[0]) return -1;
        if (v >= BASE && v < BASE + 2*N) return (v - BASE) / 2;
        return -1;
    endfunction

    function automatic logic [15:0] pick_addr();
        int k;
        k = $urandom_range(0, 13);
        if (k < 12) return addr_tbl[k];
        return 16'($urandom);
    endfunction

    initial begin
        reset          = 1'b1;
        mmio_rsp_ready = 1'b0;
        csr_rd_data    = '0;
        afu_id         = 128'hAAAA_BBBB_CCCC_DDDD_1111_2222_3333_0123;
        idle();
        tick();
        tick();

        // Reset values
        chk("rst_rsp_valid", mmio_rsp_valid, 0);
        chk("rst_rsp_tid", mmio_rsp_tid, 0);
        chk("rst_rsp_data", mmio_rsp_data, 0);
        chk("rst_wr_en", csr_wr_en, 0);
        chk("rst_wr_data", csr_wr_data, 0);
        chk("rst_drop", drop_count, 0);
        reset = 1'b0;
        tick();

        // Read of the UUID low word: response at N+2
        req(1'b0, 16'h0002, 1'b1, 9'h15, 64'h0);
        tick();
        idle();
        chk("id_lo_n1_valid", mmio_rsp_valid, 0);
        tick();
        chk("id_lo_n2_valid", mmio_rsp_valid, 1);
        chk("id_lo_tid", mmio_rsp_tid, 9'h15);
        chk("id_lo_data", mmio_rsp_data, 64'h1111_2222_3333_0123);
        mmio_rsp_ready = 1'b1;
        tick();
        chk("id_lo_popped", mmio_rsp_valid, 0);

        // Legal write strobes CSR 2 for exactly one cycle
        req(1'b1, 16'h0024, 1'b1, 9'h0, 64'hDEAD_BEEF);
        tick();
        idle();
        chk("wr_en_n1", csr_wr_en, 8'b0000_0100);
        chk("wr_data_n1", csr_wr_data, 64'hDEAD_BEEF);
        tick();
        chk("wr_en_n2", csr_wr_en, 0);
        // 4-byte write is dropped and counted
        req(1'b1, 16'h0024, 1'b0, 9'h0, 64'h1234);
        tick();
        idle();
        chk("wr4_en", csr_wr_en, 0);
        chk("wr4_drop", drop_count, 1);
        // Header write: ignored and not counted
        req(1'b1, 16'h0000, 1'b1, 9'h0, 64'h5678);
        tick();
        idle();
        chk("wrhdr_en", csr_wr_en, 0);
        chk("wrhdr_drop", drop_count, 1);
        // Back-to-back writes give consecutive strobes
        req(1'b1, 16'h0020, 1'b1, 9'h0, 64'hA0);
        tick();
        req(1'b1, 16'h002E, 1'b1, 9'h0, 64'hA7);
        chk("b2b_en0", csr_wr_en, 8'b0000_0001);
        chk("b2b_d0", csr_wr_data, 64'hA0);
        tick();
        idle();
        chk("b2b_en7", csr_wr_en, 8'b1000_0000);
        chk("b2b_d7", csr_wr_data, 64'hA7);

        // Application CSR reads, including odd 4-byte address, and unmapped read
        for (int i = 0; i < N; i++) csr_rd_data[64*i +: 64] = 64'h1000 + 64'(i);
        csr_rd_data[64*7 +: 64] = 64'h55;
        req(1'b0, 16'h002E, 1'b1, 9'h07, 64'h0);
        tick();
        req(1'b0, 16'h002F, 1'b0, 9'h08, 64'h0);
        tick();
        req(1'b0, 16'h0100, 1'b1, 9'h09, 64'h0);
        chk("app7_tid", mmio_rsp_tid, 9'h07);
        chk("app7_data", mmio_rsp_data, 64'h55);
        tick();
        req(1'b0, 16'h0005, 1'b0, 9'h0A, 64'h0);
        chk("app7odd_tid", mmio_rsp_tid, 9'h08);
        chk("app7odd_data", mmio_rsp_data, 64'h55);
        tick();
        idle();
        chk("unmap_tid", mmio_rsp_tid, 9'h09);
        chk("unmap_data", mmio_rsp_data, 64'h0);
        tick();
        chk("id_hi_tid", mmio_rsp_tid, 9'h0A);
        chk("id_hi_data", mmio_rsp_data, 64'hAAAA_BBBB_CCCC_DDDD);
        tick();
        chk("rd_done_valid", mmio_rsp_valid, 0);

        // Stalled responses: six reads, four retained, two dropped
        mmio_rsp_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            req(1'b0, 16'(BASE + 2*(k-1)), 1'b1, 9'(k), 64'h0);
            tick();
        end
        idle();
        tick();
        chk("stall_drop", drop_count, 3);
        for (int s = 0; s < 3; s++) begin
            chk("stall_hold_tid", mmio_rsp_tid, 9'd1);
            chk("stall_hold_data", mmio_rsp_data, 64'h1000);
            tick();
        end
        mmio_rsp_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("drain_valid", mmio_rsp_valid, 1);
            chk("drain_tid", mmio_rsp_tid, 9'(k));
            chk("drain_data", mmio_rsp_data, 64'h1000 + 64'(k-1));
            tick();
        end
        chk("drain_empty", mmio_rsp_valid, 0);

        // Reset with responses queued flushes them immediately
        mmio_rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req(1'b0, 16'h0000, 1'b1, 9'h21 + 9'(k), 64'h0);
            tick();
        end
        idle();
        tick();
        chk("queued_valid", mmio_rsp_valid, 1);
        reset = 1'b1;
        #1;
        chk("async_rst_valid", mmio_rsp_valid, 0);
        chk("async_rst_drop", drop_count, 0);
        tick();
        reset = 1'b0;
        req(1'b0, 16'h0000, 1'b1, 9'h33, 64'h0);
        tick();
        idle();
        chk("post_rst_n1", mmio_rsp_valid, 0);
        tick();
        chk("post_rst_n2", mmio_rsp_valid, 1);
        chk("post_rst_tid", mmio_rsp_tid, 9'h33);
        chk("post_rst_data", mmio_rsp_data, DFH);
        mmio_rsp_ready = 1'b1;
        tick();
        chk("post_rst_nostale", mmio_rsp_valid, 0);

        // Drop counter saturation
        en_seen = '0;
        for (int i = 0; i < 300; i++) begin
            if (i[0]) req(1'b1, 16'h0025, 1'b1, 9'h0, 64'h1);
            else      req(1'b1, 16'h0024, 1'b0, 9'h0, 64'h1);
            tick();
            en_seen = en_seen | csr_wr_en;
            if (i == 253) chk("sat_254", drop_count, 254);
            if (i == 255) chk("sat_255", drop_count, 255);
        end
        idle();
        tick();
        chk("sat_300", drop_count, 255);
        chk("sat_no_strobe", en_seen, 0);

        // Random traffic against the queue model
        reset = 1'b1;
        tick();
        reset = 1'b0;
        afu_id = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < N; i++) csr_rd_data[64*i +: 64] = {$urandom, $urandom};
        q.delete();
        m_drop    = 0;
        m_wr_en   = '0;
        m_wr_data = '0;
        for (int c = 0; c < 620; c++) begin
            exp_vld = (q.size() > 0) && (q[0].cyc <= now - 2);
            chk("rnd_valid", mmio_rsp_valid, exp_vld);
            if (exp_vld) begin
                chk("rnd_tid", mmio_rsp_tid, q[0].tid);
                chk("rnd_data", mmio_rsp_data, q[0].data);
            end
            chk("rnd_wr_en", csr_wr_en, m_wr_en);
            chk("rnd_wr_data", csr_wr_data, m_wr_data);
            chk("rnd_drop", drop_count, m_drop);

            mmio_rsp_ready = (c >= 600) || ($urandom_range(0, 99) < 55);
            do_pop  = exp_vld && mmio_rsp_ready;
            m_wr_en = '0;
            op = (c >= 600) ? 9 : int'($urandom_range(0, 9));
            a  = pick_addr();
            l  = 1'($urandom_range(0, 1));
            t  = 9'($urandom_range(0, 511));
            if (op <= 5) begin
                req(1'b0, a, l, t, 64'h0);
                if (q.size() < DEPTH) begin
                    e.tid  = t;
                    e.data = ref_rd(a);
                    e.cyc  = now;
                    q.push_back(e);
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end else if (op <= 7) begin
                e.data = {$urandom, $urandom};
                req(1'b1, a, l, 9'h0, e.data);
                widx = ref_wr_idx(a, l);
                if (widx >= 0) begin
                    m_wr_en[widx] = 1'b1;
                    m_wr_data     = e.data;
                end
                if ((!l || a[0]) && m_drop < 255) m_drop++;
            end else begin
                idle();
            end
            if (do_pop) void'(q.pop_front());
            tick();
        end
        idle();
        chk("rnd_final_valid", mmio_rsp_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time bound so the bench can never hang
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

endmodule
